// File: rtl/pipe_io_ctrl.sv
// pipe_io_ctrl: memory-mapped I/O responder on the MEM-stage data bus.
//
// The block decodes byte addresses 0x80-0xFF as the I/O region. Reads are
// combinational, so the MEM stage can mux rdata in the same cycle as a RAM
// read. Stores are committed on the rising clock edge.
//
// The block owns the board I/O state:
//   - synchronised switches
//   - synchronised and debounced keys
//   - sticky key-press events
//   - the LED register
//   - six registered 7-segment digit drivers
//
// Ports:
//   clock      rising-edge clock
//   resetn     asynchronous active-low reset
//   addr       byte address from the MEM stage
//   wdata      store data
//   we         store enable
//   io_sel     1 when addr lies in the I/O region
//   rdata      read data; valid while io_sel = 1, otherwise 0
//   sw         raw slide switches (asynchronous)
//   key[3:1]   raw push buttons, active-low (asynchronous)
//   led        LED register
//   hex0..hex5 7-segment drive, active-low, bit order gfedcba
//
// Register map (word offset = addr[6:2]; addr[1:0] is ignored):
//   0x80 SW      RO    {22'b0, sw_sync}
//   0x84 KEYLVL  RO    {28'b0, kdb[3:1], 1'b0}
//   0x88 KEYEVT  RW1C  {28'b0, evt[3:1], 1'b0}
//   0x8C LED     RW    {22'b0, led}
//   0x90 HEXVAL  RW    {8'b0, hv[23:0]}
//   0x94 HEXEN   RW    {26'b0, en[5:0]}
//   0x98 CYCLES  RO    free-running 32-bit counter
//
// Bus handshake: there is no valid/ready pair. A store is accepted
// unconditionally on any edge where we & io_sel. A read is always ready and
// has no side effects.
module pipe_io_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic        io_sel,
    output logic [31:0] rdata,
    input  logic [9:0]  sw,
    input  logic [3:1]  key,
    output logic [9:0]  led,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5
);

    localparam int CNT_W = 20;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [4:0] OFF_SW     = 5'h00;
    localparam logic [4:0] OFF_KEYLVL = 5'h01;
    localparam logic [4:0] OFF_KEYEVT = 5'h02;
    localparam logic [4:0] OFF_LED    = 5'h03;
    localparam logic [4:0] OFF_HEXVAL = 5'h04;
    localparam logic [4:0] OFF_HEXEN  = 5'h05;
    localparam logic [4:0] OFF_CYCLES = 5'h06;

    logic [4:0]       offset;
    logic             wr_en;
    logic [9:0]       sw_meta;
    logic [9:0]       sw_sync;
    logic [3:1]       k_meta;
    logic [3:1]       ksync;
    logic [3:1]       kdb;
    logic [3:1]       kdb_d;
    logic [CNT_W-1:0] cnt [3:1];
    logic [3:1]       evt;
    logic [3:1]       evt_clr;
    logic [23:0]      hv;
    logic [5:0]       en;
    logic [31:0]      cycles;

    // Upper store-data bits and the byte lane are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{wdata[31:24], addr[1:0]};

    assign offset = addr[6:2];
    assign io_sel = (addr[31:8] == 24'd0) && addr[7];
    assign wr_en  = we && io_sel;

    // Active-low 7-segment decode; a disabled digit is fully dark.
    function automatic logic [6:0] seg7(input logic [3:0] d, input logic on);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return on ? s : 7'b1111111;
    endfunction

    // Two-flop synchronisers. Keys are inverted so that 1 means pressed.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sw_meta <= '0;
            sw_sync <= '0;
            k_meta  <= '0;
            ksync   <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
            k_meta  <= ~key;
            ksync   <= k_meta;
        end
    end

    // Debounce: kdb flips only after DEBOUNCE_CYCLES consecutive edges of
    // disagreement with the synchronised level. Any agreement restarts the
    // count.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            kdb   <= '0;
            kdb_d <= '0;
            for (int i = 1; i <= 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            kdb_d <= kdb;
            for (int i = 1; i <= 3; i++) begin
                if (ksync[i] == kdb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    kdb[i] <= ~kdb[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Sticky press events. The set term is OR'd in after the clear, so a
    // press arriving on the same edge as a write-1-to-clear is kept.
    assign evt_clr = (wr_en && (offset == OFF_KEYEVT)) ? wdata[3:1] : 3'b000;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            evt <= '0;
        end else begin
            evt <= (evt & ~evt_clr) | (kdb & ~kdb_d);
        end
    end

    // Writable registers and the free-running cycle counter.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            led    <= '0;
            hv     <= '0;
            en     <= '0;
            cycles <= '0;
        end else begin
            cycles <= cycles + 32'd1;
            if (wr_en) begin
                case (offset)
                    OFF_LED:    led <= wdata[9:0];
                    OFF_HEXVAL: hv  <= wdata[23:0];
                    OFF_HEXEN:  en  <= wdata[5:0];
                    default:    ;
                endcase
            end
        end
    end

    // Registered digit drivers. They lag HEXVAL/HEXEN by one edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hex0 <= 7'b1111111;
            hex1 <= 7'b1111111;
            hex2 <= 7'b1111111;
            hex3 <= 7'b1111111;
            hex4 <= 7'b1111111;
            hex5 <= 7'b1111111;
        end else begin
            hex0 <= seg7(hv[3:0],   en[0]);
            hex1 <= seg7(hv[7:4],   en[1]);
            hex2 <= seg7(hv[11:8],  en[2]);
            hex3 <= seg7(hv[15:12], en[3]);
            hex4 <= seg7(hv[19:16], en[4]);
            hex5 <= seg7(hv[23:20], en[5]);
        end
    end

    // Combinational read mux. Unmapped offsets and non-I/O addresses read 0.
    always_comb begin
        rdata = '0;
        if (io_sel) begin
            case (offset)
                OFF_SW:     rdata = {22'd0, sw_sync};
                OFF_KEYLVL: rdata = {28'd0, kdb, 1'b0};
                OFF_KEYEVT: rdata = {28'd0, evt, 1'b0};
                OFF_LED:    rdata = {22'd0, led};
                OFF_HEXVAL: rdata = {8'd0, hv};
                OFF_HEXEN:  rdata = {26'd0, en};
                OFF_CYCLES: rdata = cycles;
                default:    rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_io_ctrl.sv
// tb_pipe_io_ctrl: directed bench for pipe_io_ctrl with DEBOUNCE_CYCLES = 4.
//
// The reference model tracks the sampling history of the raw inputs. It
// decides debounce flips from a sliding window over that history. A per-cycle
// compare checks io_sel, rdata, led and the hex outputs against the model.
// Directed literal checks pin the model to hand-computed values.
module tb_pipe_io_ctrl;

    localparam int D = 4;

    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        clock;
    logic        resetn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        io_sel;
    logic [31:0] rdata;
    logic [9:0]  sw;
    logic [3:1]  key;
    logic [9:0]  led;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

    int n_vec  = 0;
    int n_miss = 0;

    pipe_io_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clock  (clock),
        .resetn (resetn),
        .addr   (addr),
        .wdata  (wdata),
        .we     (we),
        .io_sel (io_sel),
        .rdata  (rdata),
        .sw     (sw),
        .key    (key),
        .led    (led),
        .hex0   (hex0),
        .hex1   (hex1),
        .hex2   (hex2),
        .hex3   (hex3),
        .hex4   (hex4),
        .hex5   (hex5)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [9:0]  m_led;
    logic [23:0] m_hv;
    logic [5:0]  m_en;
    logic [2:0]  m_evt;
    logic [2:0]  m_kdb;
    logic [2:0]  m_rose;
    logic [31:0] m_cyc;
    logic [6:0]  m_hex [6];
    logic [2:0]  k_hist [$];   // ~key sampled at each edge (bit i = key[i+1])
    logic [9:0]  s_hist [$];   // sw sampled at each edge

    function automatic logic sel_of(input logic [31:0] a);
        return (a[31:8] == 24'd0) && a[7];
    endfunction

    task automatic model_reset();
        m_led  = '0;
        m_hv   = '0;
        m_en   = '0;
        m_evt  = '0;
        m_kdb  = '0;
        m_rose = '0;
        m_cyc  = '0;
        for (int n = 0; n < 6; n++) m_hex[n] = 7'h7F;
        k_hist = {};
        s_hist = {};
        for (int j = 0; j < D + 3; j++) k_hist.push_back(3'b000);
        for (int j = 0; j < 2; j++) s_hist.push_back(10'd0);
    endtask

    // One rising edge. The level seen by the debouncer at this edge is the
    // raw sample from two edges earlier. A key flips once the last D such
    // levels all disagree with its current debounced value.
    task automatic model_step();
        logic [23:0] old_hv;
        logic [5:0]  old_en;
        logic [2:0]  new_kdb;
        logic [2:0]  clr;
        logic        all_diff;
        int          sz;
        old_hv = m_hv;
        old_en = m_en;
        k_hist.push_back(~key);
        s_hist.push_back(sw);
        sz = k_hist.size();
        new_kdb = m_kdb;
        for (int i = 0; i < 3; i++) begin
            all_diff = 1'b1;
            for (int j = 0; j < D; j++) begin
                if (k_hist[sz - 3 - j][i] == m_kdb[i]) all_diff = 1'b0;
            end
            if (all_diff) new_kdb[i] = ~m_kdb[i];
        end
        clr = (we && sel_of(addr) && addr[6:2] == 5'h02) ? wdata[3:1] : 3'b000;
        m_evt  = (m_evt & ~clr) | m_rose;
        m_rose = new_kdb & ~m_kdb;
        m_kdb  = new_kdb;
        if (we && sel_of(addr)) begin
            case (addr[6:2])
                5'h03: m_led = wdata[9:0];
                5'h04: m_hv  = wdata[23:0];
                5'h05: m_en  = wdata[5:0];
                default: ;
            endcase
        end
        for (int n = 0; n < 6; n++)
            m_hex[n] = old_en[n] ? SEG[old_hv[4*n +: 4]] : 7'h7F;
        m_cyc = m_cyc + 1;
        while (k_hist.size() > D + 8) void'(k_hist.pop_front());
        while (s_hist.size() > 8) void'(s_hist.pop_front());
    endtask

    function automatic logic [31:0] model_rdata(input logic [31:0] a);
        if (!sel_of(a)) return 32'd0;
        case (a[6:2])
            5'h00: return {22'd0, s_hist[s_hist.size() - 2]};
            5'h01: return {28'd0, m_kdb, 1'b0};
            5'h02: return {28'd0, m_evt, 1'b0};
            5'h03: return {22'd0, m_led};
            5'h04: return {8'd0, m_hv};
            5'h05: return {26'd0, m_en};
            5'h06: return m_cyc;
            default: return 32'd0;
        endcase
    endfunction

    // Per-cycle compare, taken 2 time units after each active edge.
    always @(posedge clock) begin
        if (resetn) begin
            model_step();
            #2;
            check("io_sel", {31'd0, io_sel}, {31'd0, sel_of(addr)});
            check("rdata", rdata, model_rdata(addr));
            check("led", {22'd0, led}, {22'd0, m_led});
            check("hex0", {25'd0, hex0}, {25'd0, m_hex[0]});
            check("hex1", {25'd0, hex1}, {25'd0, m_hex[1]});
            check("hex2", {25'd0, hex2}, {25'd0, m_hex[2]});
            check("hex3", {25'd0, hex3}, {25'd0, m_hex[3]});
            check("hex4", {25'd0, hex4}, {25'd0, m_hex[4]});
            check("hex5", {25'd0, hex5}, {25'd0, m_hex[5]});
        end
    end

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clock);
        we    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        addr = a;
        #1;
        check(name, rdata, exp);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        resetn = 1'b0;
        addr   = '0;
        wdata  = '0;
        we     = 1'b0;
        sw     = '0;
        key    = 3'b111;
        model_reset();
        idle(3);
        check("rst_led", {22'd0, led}, 32'd0);
        check("rst_hex0", {25'd0, hex0}, 32'h7F);
        check("rst_hex5", {25'd0, hex5}, 32'h7F);
        resetn = 1'b1;
        rd(32'h98, 32'd0, "cycles_start");

        // LED write/read, decode boundaries
        wr(32'h8C, 32'h3FF);
        check("led_val", {22'd0, led}, 32'h3FF);
        rd(32'h8C, 32'h3FF, "led_rd");
        check("led_sel", {31'd0, io_sel}, 32'd1);
        rd(32'h8F, 32'h3FF, "led_rd_bytelane");
        rd(32'h100, 32'd0, "rd_0x100");
        check("sel_0x100", {31'd0, io_sel}, 32'd0);
        rd(32'h0C, 32'd0, "rd_0x0C");
        check("sel_0x0C", {31'd0, io_sel}, 32'd0);
        wr(32'h9C, 32'h1234);
        rd(32'h9C, 32'd0, "unmapped_rd");
        rd(32'hFC, 32'd0, "unmapped_top");

        // Switch synchroniser: two edges of latency
        sw = 10'h2A5;
        idle(1);
        rd(32'h80, 32'd0, "sw_1edge");
        idle(1);
        rd(32'h80, 32'h2A5, "sw_2edge");

        // Hex display: digits A..F, then blank all but digit 0
        wr(32'h90, 32'hFFFE_DCBA);
        rd(32'h90, 32'h00FE_DCBA, "hexval_rd");
        wr(32'h94, 32'h3F);
        check("hex0_lag", {25'd0, hex0}, 32'h7F);
        idle(1);
        check("hex0_A", {25'd0, hex0}, {25'd0, 7'b0001000});
        check("hex1_b", {25'd0, hex1}, {25'd0, 7'b0000011});
        check("hex2_C", {25'd0, hex2}, {25'd0, 7'b1000110});
        check("hex3_d", {25'd0, hex3}, {25'd0, 7'b0100001});
        check("hex4_E", {25'd0, hex4}, {25'd0, 7'b0000110});
        check("hex5_F", {25'd0, hex5}, {25'd0, 7'b0001110});
        wr(32'h94, 32'hFFFF_FFC1);
        idle(1);
        rd(32'h94, 32'h01, "hexen_rd");
        check("hex0_keep", {25'd0, hex0}, {25'd0, 7'b0001000});
        check("hex1_blank", {25'd0, hex1}, 32'h7F);
        check("hex5_blank", {25'd0, hex5}, 32'h7F);

        // key[2] press: KEYLVL after 6 edges, KEYEVT after 7
        addr = 32'h84;
        key  = 3'b101;
        idle(5);
        rd(32'h84, 32'd0, "keylvl_early");
        idle(1);
        rd(32'h84, 32'h4, "keylvl_set");
        rd(32'h88, 32'd0, "keyevt_early");
        idle(1);
        rd(32'h88, 32'h4, "keyevt_set");
        idle(2);
        rd(32'h88, 32'h4, "keyevt_sticky");
        key = 3'b111;
        idle(10);
        rd(32'h84, 32'd0, "keylvl_release");
        rd(32'h88, 32'h4, "keyevt_no_release_evt");
        wr(32'h88, 32'h4);
        rd(32'h88, 32'd0, "keyevt_clear");

        // key[1] glitch of 3 synchronised cycles: no effect
        key = 3'b110;
        idle(3);
        key = 3'b111;
        idle(10);
        rd(32'h84, 32'd0, "glitch_lvl");
        rd(32'h88, 32'd0, "glitch_evt");

        // Store to a read-only register
        wr(32'h84, 32'hFFFF_FFFF);
        rd(32'h84, 32'd0, "keylvl_ro");

        // key[3]: a new event lands on the same edge as the W1C write
        key = 3'b011;
        idle(7);
        rd(32'h88, 32'h8, "evt3_first");
        key = 3'b111;
        idle(8);
        rd(32'h84, 32'd0, "key3_released");
        key = 3'b011;
        idle(6);
        rd(32'h84, 32'h8, "key3_lvl_again");
        wr(32'h88, 32'h8);
        rd(32'h88, 32'h8, "evt3_set_wins");
        wr(32'h88, 32'h8);
        rd(32'h88, 32'd0, "evt3_cleared");
        key = 3'b111;
        idle(2);

        // Asynchronous reset in the middle of a LED store
        addr  = 32'h8C;
        wdata = 32'h155;
        we    = 1'b1;
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        check("async_led", {22'd0, led}, 32'd0);
        check("async_hex0", {25'd0, hex0}, 32'h7F);
        rd(32'h98, 32'd0, "async_cycles");
        we = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        idle(3);
        rd(32'h98, 32'd3, "cycles_after_reset");
        rd(32'h8C, 32'd0, "led_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
